// File: rtl/parking_gate_controller.sv
// Single-lane parking occupancy controller: synchronises the entry/exit sensors,
// arbitrates admissions against capacity and sequences the barrier gate.
module parking_gate_controller #(
    parameter int unsigned CAPACITY    = 15,
    parameter int unsigned GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_sensor,
    input  logic       exit_sensor,
    output logic [3:0] occupancy,
    output logic       gate_open,
    output logic       enter_grant,
    output logic       exit_grant,
    output logic       reject,
    output logic       full,
    output logic       empty,
    output logic       busy
);

    localparam int unsigned OCC_W   = 4;
    localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTER_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic [OCC_W-1:0]     occ_next;
    logic                 pend_enter;
    logic                 pend_enter_next;
    logic                 pend_exit;
    logic                 pend_exit_next;
    logic                 enter_grant_next;
    logic                 exit_grant_next;
    logic                 reject_next;

    logic                 enter_s1;
    logic                 enter_s2;
    logic                 enter_prev;
    logic                 exit_s1;
    logic                 exit_s2;
    logic                 exit_prev;
    logic                 enter_evt;
    logic                 exit_evt;
    logic                 req_enter;
    logic                 req_exit;
    logic                 has_room;
    logic                 has_car;

    // Two-flop synchronisers plus edge-history flops for both sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_s1   <= 1'b0;
            enter_s2   <= 1'b0;
            enter_prev <= 1'b0;
            exit_s1    <= 1'b0;
            exit_s2    <= 1'b0;
            exit_prev  <= 1'b0;
        end else begin
            enter_s1   <= enter_sensor;
            enter_s2   <= enter_s1;
            enter_prev <= enter_s2;
            exit_s1    <= exit_sensor;
            exit_s2    <= exit_s1;
            exit_prev  <= exit_s2;
        end
    end

    assign enter_evt = enter_s2 & ~enter_prev;
    assign exit_evt  = exit_s2 & ~exit_prev;
    assign req_enter = enter_evt | pend_enter;
    assign req_exit  = exit_evt | pend_exit;
    assign has_room  = (occupancy < OCC_W'(CAPACITY));
    assign has_car   = (occupancy != '0);

    // Next-state, arbitration and pulse decode
    always_comb begin
        state_next       = state;
        timer_next       = timer;
        occ_next         = occupancy;
        pend_enter_next  = pend_enter;
        pend_exit_next   = pend_exit;
        enter_grant_next = 1'b0;
        exit_grant_next  = 1'b0;
        reject_next      = 1'b0;

        case (state)
            IDLE: begin
                if (req_exit && has_car) begin
                    occ_next        = occupancy - OCC_W'(1);
                    exit_grant_next = 1'b1;
                    pend_exit_next  = 1'b0;
                    pend_enter_next = req_enter;
                    timer_next      = TIMER_W'(GATE_CYCLES - 1);
                    state_next      = EXIT_OPEN;
                end else if (req_enter && has_room) begin
                    occ_next         = occupancy + OCC_W'(1);
                    enter_grant_next = 1'b1;
                    pend_enter_next  = 1'b0;
                    pend_exit_next   = 1'b0;
                    timer_next       = TIMER_W'(GATE_CYCLES - 1);
                    state_next       = ENTER_OPEN;
                end else begin
                    // Full-lot entry is refused; an exit from an empty lot is dropped silently
                    reject_next     = req_enter;
                    pend_enter_next = 1'b0;
                    pend_exit_next  = 1'b0;
                end
            end
            ENTER_OPEN, EXIT_OPEN: begin
                pend_enter_next = pend_enter | enter_evt;
                pend_exit_next  = pend_exit | exit_evt;
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            occupancy   <= '0;
            pend_enter  <= 1'b0;
            pend_exit   <= 1'b0;
            gate_open   <= 1'b0;
            busy        <= 1'b0;
            enter_grant <= 1'b0;
            exit_grant  <= 1'b0;
            reject      <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            occupancy   <= occ_next;
            pend_enter  <= pend_enter_next;
            pend_exit   <= pend_exit_next;
            gate_open   <= (state_next != IDLE);
            busy        <= (state_next != IDLE);
            enter_grant <= enter_grant_next;
            exit_grant  <= exit_grant_next;
            reject      <= reject_next;
            full        <= (occ_next == OCC_W'(CAPACITY));
            empty       <= (occ_next == '0);
        end
    end

endmodule
